reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Parametrised Tomasulo reservation station: NUM_ENTRIES slots, each holding op, Vj/Vk, Qj/Qk and busy.
//  Accepts issued instructions, snoops the CDB to wake waiting operands, and dispatches ready entries
//  to one functional unit (adder, multiplier, ...) over a valid/ready handshake.
//  Sits between the issue stage/register file and a functional unit. Replaces fixed 2-slot adder stations.
// PARAMETERS
//  NUM_ENTRIES  3   station depth, 1..8
//  DATA_W       16  operand/CDB data width
//  TAG_W        3   producer tag width; tag 0 = "no producer, value valid"
//  OP_W         2   operation code width (encodings in tomasulo_pkg)
//  BASE_TAG     1   tag of entry 0; entry i owns tag BASE_TAG+i (nonzero, < 2**TAG_W)
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        asynchronous, active-low reset
//  flush        in   1        synchronous: clear all entries
//  issue_valid  in   1        issue request
//  issue_ready  out  1        at least one free entry
//  issue_op     in   OP_W     operation
//  issue_vj     in   DATA_W   operand j value (used when issue_qj==0)
//  issue_qj     in   TAG_W    operand j producer tag
//  issue_vk     in   DATA_W   operand k value
//  issue_qk     in   TAG_W    operand k producer tag
//  issue_tag    out  TAG_W    tag allocated to an accepted issue (to register status table)
//  cdb_valid    in   1        CDB broadcast valid
//  cdb_tag      in   TAG_W    broadcasting producer tag
//  cdb_data     in   DATA_W   broadcast value
//  fu_valid     out  1        dispatch valid
//  fu_ready     in   1        functional unit accepts
//  fu_op        out  OP_W     dispatched op
//  fu_a/fu_b    out  DATA_W   dispatched Vj/Vk
//  fu_tag       out  TAG_W    dispatched entry tag (FU returns it on CDB)
//  busy_count   out  $clog2(NUM_ENTRIES+1)  occupied entries
// BEHAVIOUR
//  Reset (reset=0, async): all busy=0, Q*=0, V*=0; fu_valid=0, issue_ready=1, busy_count=0, fu_*/issue_tag=0.
//  Issue: accepted when issue_valid & issue_ready. Allocates lowest-index free entry (busy=0 at start
//   of cycle); entry freed this cycle is NOT reusable until next cycle. issue_tag is combinational,
//   = BASE_TAG+index of that entry, valid whenever issue_ready=1.
//  Issue-cycle bypass: if cdb_valid & issue_qj!=0 & cdb_tag==issue_qj, store Vj=cdb_data, Qj=0; same for k.
//  Wakeup: every busy entry with Qj==cdb_tag (Qj!=0) and cdb_valid latches Vj=cdb_data, Qj=0; k likewise.
//   Multiple entries may wake on one broadcast. cdb_tag==0 is ignored.
//  Ready: entry busy & Qj==0 & Qk==0 using registered state (a wakeup counts from the next cycle).
//  Dispatch: fu_valid=1 iff any entry ready; selects lowest-index ready entry; fu_* combinational from
//   it. On fu_valid & fu_ready the entry clears busy at the edge. One dispatch per cycle max.
//   fu_valid must not drop, and the selected entry must not change, while fu_ready=0, unless
//   flush/reset or a lower-index entry becomes ready (selection is recomputed each cycle).
//  Full: issue_ready=0 when all busy; issue_valid then ignored, no state change.
//  Simultaneous issue+dispatch+CDB in one cycle: all three apply independently; busy_count += issue - dispatch.
//  Flush: all busy=0 next edge; overrides issue and dispatch in that cycle; fu handshake in flush cycle
//   is discarded by the FU protocol. Reset mid-operation: immediate clear, no pending dispatch survives.
//  Widths: tags compared full-width; no arithmetic on data here. Out-of-range BASE_TAG is a fatal elaboration error.
// STRUCTURE
//  tomasulo_pkg: op encodings (OP_ADD=0, OP_SUB=1, ...), TAG_NONE=0, shared DATA_W/TAG_W defaults.
//  Sub-module rs_entry: one slot (busy, op, V/Q, wakeup compare, ready out); generate NUM_ENTRIES copies.
//  Top: priority encoders for free-slot alloc and ready-slot select, busy counter.
// TESTING
//  1 Reset, issue 3 ready ops (q=0), fu_ready=1 -> dispatched in issue order, tags 1,2,3; busy_count 0 at end.
//  2 Issue 3 with qj=5, 4th issue -> issue_ready=0, 4th ignored; CDB tag5 data 0x1234 -> all 3 fu_a=0x1234.
//  3 Issue qj=6 same cycle as CDB tag6 data 0xBEEF -> entry ready next cycle, fu_a=0xBEEF.
//  4 fu_ready=0 for 5 cycles with entry ready -> fu_valid held, fu_tag/fu_a stable; then fu_ready=1 -> freed.
//  5 Full station, dispatch and issue same cycle -> issue rejected that cycle, accepted next into freed slot.
//  6 Assert flush, and separately reset=0 mid-wait -> next cycle busy_count=0, fu_valid=0, issue_ready=1.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: operation encodings, the "no producer" tag and
// default datapath widths used by the reservation station and its slots.
package tomasulo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TAG_W_DEF  = 3;
    localparam int OP_W_DEF   = 2;
    localparam int TAG_NONE   = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an op and its two operands, and snoops the
// CDB so operands still waiting on a producer tag capture the broadcast value.
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc,
    input  logic              dispatch,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              busy,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    logic              busy_q, busy_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
    logic              hit_j, hit_k, byp_j, byp_k;

    assign hit_j = busy_q && cdb_valid && (qj_q != NO_TAG) && (qj_q == cdb_tag);
    assign hit_k = busy_q && cdb_valid && (qk_q != NO_TAG) && (qk_q == cdb_tag);
    // Producer broadcasting in the issue cycle would otherwise be missed forever.
    assign byp_j = cdb_valid && (issue_qj != NO_TAG) && (issue_qj == cdb_tag);
    assign byp_k = cdb_valid && (issue_qk != NO_TAG) && (issue_qk == cdb_tag);

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        vj_d   = vj_q;
        qj_d   = qj_q;
        vk_d   = vk_q;
        qk_d   = qk_q;
        if (flush) begin
            busy_d = 1'b0;
            qj_d   = NO_TAG;
            qk_d   = NO_TAG;
        end else if (alloc) begin
            busy_d = 1'b1;
            op_d   = issue_op;
            vj_d   = byp_j ? cdb_data : issue_vj;
            qj_d   = byp_j ? NO_TAG : issue_qj;
            vk_d   = byp_k ? cdb_data : issue_vk;
            qk_d   = byp_k ? NO_TAG : issue_qk;
        end else begin
            if (dispatch) busy_d = 1'b0;
            if (hit_j) begin
                vj_d = cdb_data;
                qj_d = NO_TAG;
            end
            if (hit_k) begin
                vk_d = cdb_data;
                qk_d = NO_TAG;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            op_q   <= '0;
            vj_q   <= '0;
            qj_q   <= '0;
            vk_q   <= '0;
            qk_q   <= '0;
        end else begin
            busy_q <= busy_d;
            op_q   <= op_d;
            vj_q   <= vj_d;
            qj_q   <= qj_d;
            vk_q   <= vk_d;
            qk_q   <= qk_d;
        end
    end

    assign busy  = busy_q;
    assign ready = busy_q && (qj_q == NO_TAG) && (qk_q == NO_TAG);
    assign op    = op_q;
    assign vj    = vj_q;
    assign vk    = vk_q;

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: allocates the lowest free slot on issue, dispatches
// the lowest ready slot to one functional unit and tracks occupancy.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 3,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int BASE_TAG    = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [OP_W-1:0]                    issue_op,
    input  logic [DATA_W-1:0]                  issue_vj,
    input  logic [TAG_W-1:0]                   issue_qj,
    input  logic [DATA_W-1:0]                  issue_vk,
    input  logic [TAG_W-1:0]                   issue_qk,
    output logic [TAG_W-1:0]                   issue_tag,
    input  logic                               cdb_valid,
    input  logic [TAG_W-1:0]                   cdb_tag,
    input  logic [DATA_W-1:0]                  cdb_data,
    output logic                               fu_valid,
    input  logic                               fu_ready,
    output logic [OP_W-1:0]                    fu_op,
    output logic [DATA_W-1:0]                  fu_a,
    output logic [DATA_W-1:0]                  fu_b,
    output logic [TAG_W-1:0]                   fu_tag,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 8 || BASE_TAG < 1 ||
        BASE_TAG + NUM_ENTRIES - 1 >= (1 << TAG_W)) begin : g_bad_cfg
        $fatal(1, "reservation_station: NUM_ENTRIES/BASE_TAG out of range for TAG_W");
    end

    logic [NUM_ENTRIES-1:0] busy, ready, alloc, disp;
    logic [OP_W-1:0]        e_op [NUM_ENTRIES];
    logic [DATA_W-1:0]      e_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]      e_vk [NUM_ENTRIES];
    logic [IDX_W-1:0]       free_idx, sel_idx;
    logic                   free_found, sel_found, issue_fire, disp_fire;
    logic [CNT_W-1:0]       count_q, count_d;

    // Both encoders scan high to low so the lowest matching index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = free_found;
    assign issue_fire  = issue_valid && free_found && !flush;
    assign issue_tag   = (issue_valid && free_found) ? TAG_W'(BASE_TAG) + TAG_W'(free_idx) : '0;

    assign fu_valid  = sel_found;
    assign disp_fire = sel_found && fu_ready && !flush;
    assign fu_op     = sel_found ? e_op[sel_idx] : '0;
    assign fu_a      = sel_found ? e_vj[sel_idx] : '0;
    assign fu_b      = sel_found ? e_vk[sel_idx] : '0;
    assign fu_tag    = sel_found ? TAG_W'(BASE_TAG) + TAG_W'(sel_idx) : '0;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        assign alloc[g] = issue_fire && (free_idx == IDX_W'(g));
        assign disp[g]  = disp_fire && (sel_idx == IDX_W'(g));

        rs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OP_W   (OP_W)
        ) u_entry (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .alloc     (alloc[g]),
            .dispatch  (disp[g]),
            .issue_op  (issue_op),
            .issue_vj  (issue_vj),
            .issue_qj  (issue_qj),
            .issue_vk  (issue_vk),
            .issue_qk  (issue_qk),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .busy      (busy[g]),
            .ready     (ready[g]),
            .op        (e_op[g]),
            .vj        (e_vj[g]),
            .vk        (e_vk[g])
        );
    end

    always_comb begin
        count_d = count_q;
        if (flush) count_d = '0;
        else       count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign busy_count = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner
// sequences, then randomized traffic against a slot-level reference model.
module tb_reservation_station;
    import tomasulo_pkg::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int OW = 2;
    localparam int BT = 1;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [OW-1:0] issue_op = '0;
    logic [DW-1:0] issue_vj = '0;
    logic [TW-1:0] issue_qj = '0;
    logic [DW-1:0] issue_vk = '0;
    logic [TW-1:0] issue_qk = '0;
    logic [TW-1:0] issue_tag;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          fu_valid;
    logic          fu_ready = 1'b0;
    logic [OW-1:0] fu_op;
    logic [DW-1:0] fu_a;
    logic [DW-1:0] fu_b;
    logic [TW-1:0] fu_tag;
    logic [CW-1:0] busy_count;

    reservation_station #(
        .NUM_ENTRIES (N),
        .DATA_W      (DW),
        .TAG_W       (TW),
        .OP_W        (OW),
        .BASE_TAG    (BT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_vj    (issue_vj),
        .issue_qj    (issue_qj),
        .issue_vk    (issue_vk),
        .issue_qk    (issue_qk),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_op       (fu_op),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_tag      (fu_tag),
        .busy_count  (busy_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; fu_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_issue(input int op, input int vj, input int qj, input int vk, input int qk);
        issue_valid = 1'b1;
        issue_op = OW'(op); issue_vj = DW'(vj); issue_qj = TW'(qj);
        issue_vk = DW'(vk); issue_qk = TW'(qk);
    endtask

    typedef struct {
        logic          iv;
        logic [OW-1:0] op;
        logic [DW-1:0] vj;
        logic [TW-1:0] qj;
        logic [DW-1:0] vk;
        logic [TW-1:0] qk;
        logic          cv;
        logic [TW-1:0] ct;
        logic [DW-1:0] cd;
        logic          fr;
        logic          e_ir;
        logic [TW-1:0] e_itag;
        logic          e_fv;
        logic [TW-1:0] e_ftag;
        logic [DW-1:0] e_fa;
        logic [CW-1:0] e_bc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int iv, int op, int vj, int qj, int vk, int qk,
                                int cv, int ct, int cd, int fr,
                                int ir, int itag, int fv, int ftag, int fa, int bc);
        vec_t v;
        v.iv = 1'(iv); v.op = OW'(op); v.vj = DW'(vj); v.qj = TW'(qj);
        v.vk = DW'(vk); v.qk = TW'(qk); v.cv = 1'(cv); v.ct = TW'(ct);
        v.cd = DW'(cd); v.fr = 1'(fr); v.e_ir = 1'(ir); v.e_itag = TW'(itag);
        v.e_fv = 1'(fv); v.e_ftag = TW'(ftag); v.e_fa = DW'(fa); v.e_bc = CW'(bc);
        return v;
    endfunction

    // Reference model: one record per slot, outputs derived by plain search.
    typedef struct {
        bit            busy;
        logic [OW-1:0] op;
        logic [DW-1:0] vj;
        logic [TW-1:0] qj;
        logic [DW-1:0] vk;
        logic [TW-1:0] qk;
    } ment_t;

    ment_t m[N];

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m[i].busy = 0; m[i].op = '0; m[i].vj = '0; m[i].qj = '0; m[i].vk = '0; m[i].qk = '0;
        end
    endtask

    task automatic model_check_and_step(input int cyc);
        int fi, si, cnt;
        fi = -1; si = -1; cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (!m[i].busy && fi < 0) fi = i;
            if (m[i].busy && m[i].qj == 0 && m[i].qk == 0 && si < 0) si = i;
            if (m[i].busy) cnt++;
        end
        chk($sformatf("rnd%0d_issue_ready", cyc), 32'(issue_ready), 32'(fi >= 0));
        chk($sformatf("rnd%0d_issue_tag", cyc), 32'(issue_tag),
            (issue_valid && fi >= 0) ? 32'(BT + fi) : 32'd0);
        chk($sformatf("rnd%0d_fu_valid", cyc), 32'(fu_valid), 32'(si >= 0));
        chk($sformatf("rnd%0d_fu_tag", cyc), 32'(fu_tag), (si >= 0) ? 32'(BT + si) : 32'd0);
        chk($sformatf("rnd%0d_fu_op", cyc), 32'(fu_op), (si >= 0) ? 32'(m[si].op) : 32'd0);
        chk($sformatf("rnd%0d_fu_a", cyc), 32'(fu_a), (si >= 0) ? 32'(m[si].vj) : 32'd0);
        chk($sformatf("rnd%0d_fu_b", cyc), 32'(fu_b), (si >= 0) ? 32'(m[si].vk) : 32'd0);
        chk($sformatf("rnd%0d_busy_count", cyc), 32'(busy_count), 32'(cnt));
        if (flush) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && cdb_valid && cdb_tag != 0) begin
                    if (m[i].qj == cdb_tag) begin m[i].vj = cdb_data; m[i].qj = '0; end
                    if (m[i].qk == cdb_tag) begin m[i].vk = cdb_data; m[i].qk = '0; end
                end
            end
            if (si >= 0 && fu_ready) m[si].busy = 0;
            if (issue_valid && fi >= 0) begin
                m[fi].busy = 1;
                m[fi].op   = issue_op;
                if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin
                    m[fi].vj = cdb_data; m[fi].qj = '0;
                end else begin
                    m[fi].vj = issue_vj; m[fi].qj = issue_qj;
                end
                if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin
                    m[fi].vk = cdb_data; m[fi].qk = '0;
                end else begin
                    m[fi].vk = issue_vk; m[fi].qk = issue_qk;
                end
            end
        end
    endtask

    initial begin
        // In-order dispatch of three ready ops
        tbl.push_back(mk(1, 0, 'h0011, 0, 'h00A1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h0022, 0, 'h00A2, 0, 0, 0, 0, 0,  1, 2, 1, 1, 'h0011, 1));
        tbl.push_back(mk(1, 2, 'h0033, 0, 'h00A3, 0, 0, 0, 0, 0,  1, 3, 1, 1, 'h0011, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 1, 1, 'h0011, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 1, 2, 'h0022, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 1, 3, 'h0033, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 0, 0, 0, 0));
        // Three waiting on tag 5, full-station rejection, one broadcast wakes all
        tbl.push_back(mk(1, 0, 'hDEAD, 5, 'h0101, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'hDEAD, 5, 'h0202, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 'hDEAD, 5, 'h0303, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 2));
        tbl.push_back(mk(1, 3, 'h0999, 0, 'h0999, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 'h1234, 0,       0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 1, 1, 'h1234, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 1, 2, 'h1234, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 1, 3, 'h1234, 1));
        // Issue-cycle CDB bypass
        tbl.push_back(mk(1, 0, 'h0000, 6, 'h0077, 0, 1, 6, 'hBEEF, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 1, 1, 'hBEEF, 1));

        do_reset();
        #2;
        chk("reset_issue_ready", 32'(issue_ready), 32'd1);
        chk("reset_fu_valid", 32'(fu_valid), 32'd0);
        chk("reset_busy_count", 32'(busy_count), 32'd0);
        chk("reset_fu_tag", 32'(fu_tag), 32'd0);
        chk("reset_fu_a", 32'(fu_a), 32'd0);
        chk("reset_issue_tag", 32'(issue_tag), 32'd0);
        tick();

        foreach (tbl[i]) begin
            issue_valid = tbl[i].iv; issue_op = tbl[i].op;
            issue_vj = tbl[i].vj; issue_qj = tbl[i].qj;
            issue_vk = tbl[i].vk; issue_qk = tbl[i].qk;
            cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_data = tbl[i].cd;
            fu_ready = tbl[i].fr;
            #2;
            chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_issue_tag", i), 32'(issue_tag), 32'(tbl[i].e_itag));
            chk($sformatf("v%0d_fu_valid", i), 32'(fu_valid), 32'(tbl[i].e_fv));
            chk($sformatf("v%0d_fu_tag", i), 32'(fu_tag), 32'(tbl[i].e_ftag));
            chk($sformatf("v%0d_fu_a", i), 32'(fu_a), 32'(tbl[i].e_fa));
            chk($sformatf("v%0d_busy_count", i), 32'(busy_count), 32'(tbl[i].e_bc));
            tick();
        end

        // Back-pressure: selection must hold steady while fu_ready is low
        idle();
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("hold%0d_fu_valid", c), 32'(fu_valid), 32'd1);
            chk($sformatf("hold%0d_fu_tag", c), 32'(fu_tag), 32'd1);
            chk($sformatf("hold%0d_fu_a", c), 32'(fu_a), 32'hBEEF);
            chk($sformatf("hold%0d_fu_b", c), 32'(fu_b), 32'h0077);
            tick();
        end
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        #2;
        chk("hold_release_busy_count", 32'(busy_count), 32'd0);
        chk("hold_release_fu_valid", 32'(fu_valid), 32'd0);
        tick();

        // Full station: dispatch frees a slot, but it is not reusable the same cycle
        set_issue(0, 'h0A01, 0, 1, 0); tick();
        set_issue(0, 'h0A02, 0, 2, 0); tick();
        set_issue(0, 'h0A03, 0, 3, 0); tick();
        set_issue(2, 'h0B0B, 0, 4, 0);
        fu_ready = 1'b1;
        #2;
        chk("full_issue_ready", 32'(issue_ready), 32'd0);
        chk("full_fu_tag", 32'(fu_tag), 32'd1);
        tick();
        fu_ready = 1'b0;
        #2;
        chk("full_after_busy_count", 32'(busy_count), 32'd2);
        chk("full_after_issue_ready", 32'(issue_ready), 32'd1);
        chk("full_after_issue_tag", 32'(issue_tag), 32'd1);
        tick();
        idle();
        fu_ready = 1'b1;
        #2;
        chk("reuse_busy_count", 32'(busy_count), 32'd3);
        chk("reuse_fu_tag", 32'(fu_tag), 32'd1);
        chk("reuse_fu_a", 32'(fu_a), 32'h0B0B);
        chk("reuse_fu_op", 32'(fu_op), 32'(OP_MUL));
        tick();

        // Flush overrides a simultaneous issue and dispatch
        set_issue(0, 'h0C0C, 0, 0, 0);
        fu_ready = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        #2;
        chk("flush_busy_count", 32'(busy_count), 32'd0);
        chk("flush_fu_valid", 32'(fu_valid), 32'd0);
        chk("flush_issue_ready", 32'(issue_ready), 32'd1);
        tick();

        // Asynchronous reset in the middle of a cycle with a pending dispatch
        set_issue(0, 'h0D0D, 7, 0, 0); tick();
        set_issue(0, 'h0E0E, 0, 0, 0); tick();
        idle();
        #2;
        chk("prereset_fu_valid", 32'(fu_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_busy_count", 32'(busy_count), 32'd0);
        chk("midreset_fu_valid", 32'(fu_valid), 32'd0);
        chk("midreset_issue_ready", 32'(issue_ready), 32'd1);
        #2;
        reset = 1'b1;
        tick();

        // Randomized traffic against the reference model
        do_reset();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            issue_valid = ($urandom_range(0, 99) < 60);
            issue_op = OW'($urandom_range(0, 3));
            issue_vj = DW'($urandom);
            issue_qj = ($urandom_range(0, 1) == 1) ? '0 : TW'($urandom_range(1, 7));
            issue_vk = DW'($urandom);
            issue_qk = ($urandom_range(0, 1) == 1) ? '0 : TW'($urandom_range(1, 7));
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag = TW'($urandom_range(0, 7));
            cdb_data = DW'($urandom);
            fu_ready = ($urandom_range(0, 99) < 50);
            flush = ($urandom_range(0, 99) < 3);
            #2;
            model_check_and_step(c);
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
